uart_tx_drain: RTL and testbench
================================

UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 16, giving clock cycles per serial bit; legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port fifo_empty, input, 1 bit: upstream FIFO holds no data.
REQ-005 The block SHALL have port fifo_rdata, input, 8 bits: upstream FIFO head word, valid whenever fifo_empty is low.
REQ-006 The block SHALL have port fifo_rready, output, 1 bit: pop strobe to upstream FIFO; the FIFO advances on the rising edge where it is high.
REQ-007 The block SHALL have port txd, output, 1 bit: serial line, idle high.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.

Function
REQ-009 The block SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-010 fifo_rready SHALL be combinational: high exactly when state is IDLE and fifo_empty is low; otherwise low.
REQ-011 On an edge with fifo_rready high, the block SHALL capture fifo_rdata into an 8-bit shift register, clear the bit-cycle counter and bit index, and enter START.
REQ-012 The bit-cycle counter SHALL count 0..BAUD_DIV-1; each of START, each DATA bit, PARITY and STOP SHALL last exactly BAUD_DIV cycles.
REQ-013 txd SHALL be registered: 1 in IDLE and STOP, 0 in START, shift register bit 0 in DATA, parity bit in PARITY.
REQ-014 DATA SHALL send 8 bits LSB first; the shift register shifts right by one at each bit boundary; bit index 0..7, leaving DATA after index 7 completes.
REQ-015 DATA SHALL go to PARITY when the parity feature is compiled in, else directly to STOP.
REQ-016 STOP SHALL return to IDLE after BAUD_DIV cycles; with fifo_empty low, the next pop occurs in that first IDLE cycle, giving exactly 1 idle-high cycle between back-to-back frames.
REQ-017 busy SHALL equal (state != IDLE).
REQ-018 fifo_empty changing mid-frame SHALL have no effect until the FSM is in IDLE; at most one pop SHALL occur per frame.
REQ-019 The counter width SHALL be the minimum bits holding BAUD_DIV-1; no wrap beyond BAUD_DIV-1.

Reset
REQ-020 While rst is high, state SHALL be IDLE, txd 1, busy 0, fifo_rready 0, counter, bit index and shift register 0.
REQ-021 Reset asserted mid-frame SHALL abort the frame immediately (txd 1 without waiting for a clock edge); the aborted byte SHALL NOT be re-popped or resent.
REQ-022 On the first edge after rst deasserts, the block SHALL be able to pop if fifo_empty is low.

Configuration
REQ-023 Macro UART_TX_PARITY_EN SHALL, when defined, include the PARITY state sending even parity (XOR of the 8 captured bits), making an 11-bit frame of 11*BAUD_DIV cycles.
REQ-024 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent and the frame SHALL be 10 bits, 10*BAUD_DIV cycles.

Verification
REQ-025 BAUD_DIV=4, no parity, FIFO holding 0x55 -> one-cycle fifo_rready pulse; txd 0 for 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, then 1 for 4 cycles; busy high 40 cycles.
REQ-026 BAUD_DIV=4, FIFO holding 0xA3 then 0x0F -> two pops exactly 41 cycles apart; second start bit follows stop bit after 1 idle cycle; decoded bytes 0xA3, 0x0F.
REQ-027 fifo_empty held high for 100 cycles after reset -> fifo_rready never high, txd constant 1, busy 0.
REQ-028 rst pulsed during DATA bit 3 of 0x81 -> txd 1 and busy 0 immediately; with FIFO empty afterward, no further frame and no pop.
REQ-029 UART_TX_PARITY_EN defined, BAUD_DIV=4, bytes 0x07 and 0x03 -> parity bit 1 then 0; each frame 44 cycles.
REQ-030 BAUD_DIV=2 minimum, byte 0xFF -> start bit 2 cycles, 8 high data bits of 2 cycles each, stop 2 cycles; frame 20 cycles.

Source files
------------

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops bytes from an upstream FIFO and sends each one as an
// 8N1 UART frame, LSB first. The frame is start, 8 data bits and stop.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit, which gives 8E1 framing.
// BAUD_DIV sets how many clock cycles each serial bit lasts.
module uart_tx_drain #(
   parameter int unsigned BAUD_DIV = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_rdata,
   output logic       fifo_rready,
   output logic       txd,
   output logic       busy
);

   localparam int unsigned CNT_W   = $clog2(BAUD_DIV);
   localparam int unsigned IDX_W   = 3;
   localparam int unsigned DATA_W  = 8;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

   logic [2:0]        state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt;
   logic [DATA_W-1:0] shreg, shreg_nxt;
   logic              txd_nxt;
   logic              cnt_last;
`ifdef UART_TX_PARITY_EN
   logic              par_bit;
`endif

   // Pop strobe: only in IDLE and never while reset is held
   assign fifo_rready = !rst && (state == S_IDLE) && !fifo_empty;

   assign cnt_last = (cnt == CNT_LAST);

   // Next-state, counter, bit index, shift register and serial-line value
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      shreg_nxt = shreg;
      txd_nxt   = 1'b1;

      case (state)
         S_IDLE: begin
            if (fifo_rready) begin
               shreg_nxt = fifo_rdata;
               cnt_nxt   = '0;
               idx_nxt   = '0;
               state_nxt = S_START;
            end
         end
         S_START: begin
            if (cnt_last) begin
               cnt_nxt   = '0;
               state_nxt = S_DATA;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (cnt_last) begin
               cnt_nxt   = '0;
               shreg_nxt = {1'b0, shreg[DATA_W-1:1]};
               if (idx == IDX_W'(DATA_W - 1)) begin
                  idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
                  state_nxt = S_PARITY;
`else
                  state_nxt = S_STOP;
`endif
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (cnt_last) begin
               cnt_nxt   = '0;
               state_nxt = S_STOP;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
`endif
         S_STOP: begin
            if (cnt_last) begin
               cnt_nxt   = '0;
               state_nxt = S_IDLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            cnt_nxt   = '0;
            idx_nxt   = '0;
            state_nxt = S_IDLE;
         end
      endcase

      // The line value follows the state being entered, so txd is aligned with the state
      case (state_nxt)
         S_START:  txd_nxt = 1'b0;
         S_DATA:   txd_nxt = shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: txd_nxt = par_bit;
`endif
         default:  txd_nxt = 1'b1;
      endcase
   end

   // State and datapath registers; reset forces the line idle immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
         txd   <= 1'b1;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         shreg <= shreg_nxt;
         txd   <= txd_nxt;
         busy  <= (state_nxt != S_IDLE);
      end
   end

`ifdef UART_TX_PARITY_EN
   // Even parity over the captured byte, latched on the pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_bit <= 1'b0;
      end else if (fifo_rready) begin
         par_bit <= ^fifo_rdata;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: directed checks of uart_tx_drain at BAUD_DIV=4 and BAUD_DIV=2.
// Honors UART_TX_PARITY_EN (11-bit frames) when defined.
module tb_uart_tx_drain;

`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   // FIFO model for the BAUD_DIV=4 instance
   logic [7:0]  mem4 [16];
   logic [31:0] wr4 = 0;
   logic [31:0] rd4 = 0;
   logic        fe4, rr4, txd4, busy4;
   logic [7:0]  rdata4;

   // FIFO model for the BAUD_DIV=2 instance
   logic [7:0]  mem2 [4];
   logic [31:0] wr2 = 0;
   logic [31:0] rd2 = 0;
   logic        fe2, rr2, txd2, busy2;
   logic [7:0]  rdata2;

   int n_total = 0;
   int n_bad   = 0;

   assign fe4    = (wr4 == rd4);
   assign rdata4 = mem4[rd4[3:0]];
   assign fe2    = (wr2 == rd2);
   assign rdata2 = mem2[rd2[1:0]];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rr4) rd4 <= rd4 + 1;
      if (rr2) rd2 <= rd2 + 1;
   end

   uart_tx_drain #(.BAUD_DIV(4)) u_dut4 (
      .clk(clk), .rst(rst), .fifo_empty(fe4), .fifo_rdata(rdata4),
      .fifo_rready(rr4), .txd(txd4), .busy(busy4)
   );

   uart_tx_drain #(.BAUD_DIV(2)) u_dut2 (
      .clk(clk), .rst(rst), .fifo_empty(fe2), .fifo_rdata(rdata2),
      .fifo_rready(rr2), .txd(txd2), .busy(busy2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push4(input logic [7:0] b);
      mem4[wr4[3:0]] = b;
      wr4 = wr4 + 1;
   endtask

   // Expected line value in cycle k of a frame of byte b
   function automatic logic exp_line(input logic [7:0] b, input logic par, input int k, input int baud);
      int slot;
      slot = k / baud;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
      if (slot == 9 && NBITS == 11) return par;
      return 1'b1;
   endfunction

   // Called at the negedge where the pop strobe is high; checks the whole frame
   // and the single idle cycle after it
   task automatic frame4(input logic [7:0] b, input logic par, input logic nxt);
      int bad_line = 0;
      int bad_busy = 0;
      int bad_pop  = 0;
      for (int k = 0; k < NBITS*4; k++) begin
         @(negedge clk);
         if (txd4 !== exp_line(b, par, k, 4)) bad_line++;
         if (busy4 !== 1'b1) bad_busy++;
         if (rr4 !== 1'b0) bad_pop++;
      end
      check("frame_line", 32'(bad_line), 0);
      check("frame_busy", 32'(bad_busy), 0);
      check("frame_pops", 32'(bad_pop), 0);
      @(negedge clk);
      check("gap_txd", 32'(txd4), 1);
      check("gap_busy", 32'(busy4), 0);
      check("gap_pop", 32'(rr4), 32'(nxt));
   endtask

   initial begin
      int bl, bb, bp;

      // Reset state, with data already waiting
      push4(8'h55);
      @(negedge clk);
      check("rst_txd", 32'(txd4), 1);
      check("rst_busy", 32'(busy4), 0);
      check("rst_pop", 32'(rr4), 0);
      rst = 1'b0;
      #1;
      check("pop_after_rst", 32'(rr4), 1);

      // 0x55 single frame
      frame4(8'h55, 1'b0, 1'b0);

      // Back-to-back 0xA3 then 0x0F, pops 41 cycles apart
      push4(8'hA3);
      push4(8'h0F);
      #1;
      check("pop_a3", 32'(rr4), 1);
      frame4(8'hA3, 1'b0, 1'b1);
      frame4(8'h0F, 1'b0, 1'b0);

      // FIFO empty for 100 cycles: nothing happens
      bl = 0; bb = 0; bp = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (txd4 !== 1'b1) bl++;
         if (busy4 !== 1'b0) bb++;
         if (rr4 !== 1'b0) bp++;
      end
      check("empty_txd", 32'(bl), 0);
      check("empty_busy", 32'(bb), 0);
      check("empty_pop", 32'(bp), 0);

      // Reset during data bit 3 of 0x81
      push4(8'h81);
      #1;
      check("pop_81", 32'(rr4), 1);
      for (int k = 0; k < 4*4 + 2; k++) @(negedge clk);
      check("bit3_txd", 32'(txd4), 0);
      check("bit3_busy", 32'(busy4), 1);
      rst = 1'b1;
      #1;
      check("abort_txd", 32'(txd4), 1);
      check("abort_busy", 32'(busy4), 0);
      @(negedge clk);
      rst = 1'b0;
      bl = 0; bb = 0; bp = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (txd4 !== 1'b1) bl++;
         if (busy4 !== 1'b0) bb++;
         if (rr4 !== 1'b0) bp++;
      end
      check("post_abort_txd", 32'(bl), 0);
      check("post_abort_busy", 32'(bb), 0);
      check("post_abort_pop", 32'(bp), 0);
      check("post_abort_reads", rd4, 32'd4);

      // Parity pattern bytes: 0x07 has odd weight (parity 1), 0x03 even (parity 0)
      push4(8'h07);
      push4(8'h03);
      #1;
      check("pop_07", 32'(rr4), 1);
      frame4(8'h07, 1'b1, 1'b1);
      frame4(8'h03, 1'b0, 1'b0);

      // Minimum divider, 0xFF
      mem2[0] = 8'hFF;
      wr2 = 1;
      #1;
      check("pop_ff", 32'(rr2), 1);
      bl = 0; bb = 0;
      for (int k = 0; k < NBITS*2; k++) begin
         @(negedge clk);
         if (txd2 !== exp_line(8'hFF, 1'b0, k, 2)) bl++;
         if (busy2 !== 1'b1) bb++;
      end
      check("b2_line", 32'(bl), 0);
      check("b2_busy", 32'(bb), 0);
      @(negedge clk);
      check("b2_end_busy", 32'(busy2), 0);
      check("b2_end_txd", 32'(txd2), 1);
      check("b2_reads", rd2, 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
